// File: rtl/in_port_ctrl_pkg.sv
// +---------------------------------------------------------------------+
// | in_port_pkg                                                         |
// | Shared defaults and width helpers for the buffered input port.      |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
`default_nettype none

package in_port_pkg;

    localparam int c_DEF_DATA_W = 32;
    localparam int c_DEF_DEPTH  = 4;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int c_DEF_PTR_W = $clog2(c_DEF_DEPTH);
    localparam int c_DEF_CNT_W = $clog2(c_DEF_DEPTH) + 1;

endpackage

`default_nettype wire

// File: rtl/in_port_ctrl_if.sv
// +---------------------------------------------------------------------+
// | in_port_ctrl_if                                                     |
// | Device handshake and datapath bus signals of the input port.        |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
`default_nettype none

interface in_port_ctrl_if
    import in_port_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int DEPTH  = c_DEF_DEPTH
);

    logic [DATA_W-1:0]           dev_data;
    logic                        dev_valid;
    logic                        dev_ready;
    logic                        IN_Portout;
    logic [DATA_W-1:0]           in_bus_data;
    logic                        in_empty;
    logic [cnt_width(DEPTH)-1:0] in_count;
    logic                        in_underflow;

    // Master: external device plus control unit; slave: the port itself.
    modport master (
        output dev_data, dev_valid, IN_Portout,
        input  dev_ready, in_bus_data, in_empty, in_count, in_underflow
    );

    modport slave (
        input  dev_data, dev_valid, IN_Portout,
        output dev_ready, in_bus_data, in_empty, in_count, in_underflow
    );

endinterface

`default_nettype wire

// File: rtl/in_port_ctrl_sync_fifo.sv
// +---------------------------------------------------------------------+
// | sync_fifo                                                           |
// | Single-clock FIFO: storage, wrapping pointers, occupancy count.     |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
`default_nettype none

module sync_fifo
    import in_port_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int DEPTH  = c_DEF_DEPTH
) (
    input  wire logic                        clk,
    input  wire logic                        clr,
    input  wire logic                        i_push,
    input  wire logic [DATA_W-1:0]           i_wr_data,
    input  wire logic                        i_pop,
    output      logic [DATA_W-1:0]           o_rd_data,
    output      logic [cnt_width(DEPTH)-1:0] o_count,
    output      logic                        o_full,
    output      logic                        o_empty
);

    localparam int c_PTR_W = ptr_width(DEPTH);
    localparam int c_CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (clr && w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/in_port_ctrl.sv
// +---------------------------------------------------------------------+
// | in_port_ctrl                                                        |
// | Buffered datapath input port; IN_PORT_EDGE_POP_EN pops on the       |
// | rising edge of IN_Portout instead of its level.                     |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
`default_nettype none

module in_port_ctrl
    import in_port_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int DEPTH  = c_DEF_DEPTH
) (
    input wire logic      clk,
    input wire logic      clr,
    in_port_ctrl_if.slave bus
);

    localparam int c_CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0]  w_rd_data;
    logic [c_CNT_W-1:0] w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop_req;
    logic               r_underflow;

    assign w_push = bus.dev_valid && !w_full;

`ifdef IN_PORT_EDGE_POP_EN
    logic r_portout_d;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_portout_d <= 1'b0;
        end else begin
            r_portout_d <= bus.IN_Portout;
        end
    end

    assign w_pop_req = bus.IN_Portout && !r_portout_d;
`else
    assign w_pop_req = bus.IN_Portout;
`endif

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .i_push    (w_push),
        .i_wr_data (bus.dev_data),
        .i_pop     (w_pop_req),
        .o_rd_data (w_rd_data),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_underflow <= 1'b0;
        end else if (w_pop_req && w_empty) begin
            r_underflow <= 1'b1;
        end
    end

    // Stale storage must never reach the bus mux when nothing is queued.
    assign bus.in_bus_data  = w_empty ? '0 : w_rd_data;
    assign bus.dev_ready    = !w_full;
    assign bus.in_empty     = w_empty;
    assign bus.in_count     = w_count;
    assign bus.in_underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_in_port_ctrl.sv
// +---------------------------------------------------------------------+
// | tb_in_port_ctrl                                                     |
// | Scoreboard bench for in_port_ctrl (level or edge pop build).        |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
`default_nettype none

module tb_in_port_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;

    in_port_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) pif ();

    in_port_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (pif.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] sb_q [$];
    bit                m_uf   = 1'b0;
    bit                m_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one clock, updating the scoreboard from the inputs now driven.
    task automatic cycle();
        bit req, acc, pp;
`ifdef IN_PORT_EDGE_POP_EN
        req = pif.IN_Portout && !m_prev;
`else
        req = pif.IN_Portout;
`endif
        if (!clr) begin
            sb_q.delete();
            m_uf   = 1'b0;
            m_prev = 1'b0;
        end else begin
            check("ready", 64'(pif.dev_ready), 64'(sb_q.size() != DEPTH));
            acc = pif.dev_valid && (sb_q.size() != DEPTH);
            pp  = req && (sb_q.size() != 0);
            if (req && sb_q.size() == 0) m_uf = 1'b1;
            if (pp) begin
                check("pop_bus", 64'(pif.in_bus_data), 64'(sb_q[0]));
                void'(sb_q.pop_front());
            end
            if (acc) sb_q.push_back(pif.dev_data);
            m_prev = pif.IN_Portout;
        end
        @(posedge clk);
        #1;
        check("count", 64'(pif.in_count), 64'(sb_q.size()));
        check("empty", 64'(pif.in_empty), 64'(sb_q.size() == 0));
        check("uflow", 64'(pif.in_underflow), 64'(m_uf));
        check("bus", 64'(pif.in_bus_data), (sb_q.size() != 0) ? 64'(sb_q[0]) : 64'd0);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        pif.dev_valid  = 1'b1;
        pif.dev_data   = d;
        pif.IN_Portout = 1'b0;
        cycle();
        pif.dev_valid  = 1'b0;
    endtask

    task automatic pulse_pop();
        pif.dev_valid  = 1'b0;
        pif.IN_Portout = 1'b1;
        cycle();
        pif.IN_Portout = 1'b0;
        cycle();
    endtask

    initial begin
        pif.dev_data   = 32'h99;
        pif.dev_valid  = 1'b1;
        pif.IN_Portout = 1'b1;

        // Reset with traffic asserted
        clr = 1'b0;
        cycle();
        cycle();
        check("rst_ready", 64'(pif.dev_ready), 64'd1);
        clr = 1'b1;
        pif.dev_valid  = 1'b0;
        pif.IN_Portout = 1'b0;
        cycle();

        // Fill, then an offer while full
        push(32'h11);
        push(32'h22);
        push(32'h33);
        push(32'h44);
        check("full_ready", 64'(pif.dev_ready), 64'd0);
        push(32'h55);
        check("full_count", 64'(pif.in_count), 64'd4);
        check("full_head", 64'(pif.in_bus_data), 64'h11);

        // Drain in order
        for (int i = 0; i < 4; i++) pulse_pop();
        check("drained_bus", 64'(pif.in_bus_data), 64'd0);

        // Simultaneous push and pop at count 2
        push(32'h77);
        push(32'h88);
        pif.dev_valid  = 1'b1;
        pif.dev_data   = 32'h66;
        pif.IN_Portout = 1'b1;
        cycle();
        pif.dev_valid  = 1'b0;
        pif.IN_Portout = 1'b0;
        check("simul_count", 64'(pif.in_count), 64'd2);
        check("simul_head", 64'(pif.in_bus_data), 64'h88);
        cycle();
        pulse_pop();
        pulse_pop();

        // Underflow is sticky until reset
        pulse_pop();
        push(32'h12);
        check("uflow_sticky", 64'(pif.in_underflow), 64'd1);
        clr = 1'b0;
        cycle();
        clr = 1'b1;
        cycle();
        check("uflow_clr", 64'(pif.in_underflow), 64'd0);

        // Strobe held for three cycles with three words queued
        push(32'hA1);
        push(32'hA2);
        push(32'hA3);
        pif.IN_Portout = 1'b1;
        cycle();
        cycle();
        cycle();
        pif.IN_Portout = 1'b0;
`ifdef IN_PORT_EDGE_POP_EN
        check("held_pop", 64'(pif.in_count), 64'd2);
`else
        check("held_pop", 64'(pif.in_count), 64'd0);
`endif
        cycle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            pif.dev_data   = $urandom;
            pif.dev_valid  = ($urandom_range(0, 3) != 0);
            pif.IN_Portout = ($urandom_range(0, 2) == 0);
            clr            = ($urandom_range(0, 60) != 0);
            cycle();
        end
        clr = 1'b1;
        pif.dev_valid  = 1'b0;
        pif.IN_Portout = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
